// File: rtl/param_serialiser_if.sv
// Handshake bundle between the frame/CRC generator, the serialiser and the Tx bit encoder.
// The master side is the word source plus bit sink; the slave side is the serialiser itself.
interface param_serialiser_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [CW-1:0]         in_bits;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_data;
    logic                  out_parity;
    logic                  out_last_bit;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_last_bit, out_last
    );

    modport slave (
        input  in_valid, in_data, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_last_bit, out_last
    );
endinterface

// File: rtl/param_serialiser.sv
// Parallel-word to bit-stream serialiser with configurable width, bit order and optional
// per-word parity; zero-bubble reload when a new word is accepted on the final bit.
module param_serialiser #(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1
) (
    input logic clk,
    input logic rst,
    param_serialiser_if.slave bus
);
    localparam int   CW      = $clog2(DATA_WIDTH + 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    localparam logic PAR_ON  = (PARITY_EN != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [CW-1:0]         cnt_q;
    logic                  acc_q;
    logic                  last_q;
    logic                  outValid_q;
    logic                  outData_q;
    logic                  outParity_q;
    logic                  outLastBit_q;
    logic                  outLast_q;

    logic [CW-1:0]         nBits;
    logic [CW-1:0]         shiftAmt;
    logic [DATA_WIDTH-1:0] loadWord;
    logic                  firstBit;
    logic                  nextBit;
    logic                  fire;
    logic                  accept;

    // MSB-first words are left-aligned on load so the current bit always sits at the top.
    always_comb begin
        nBits    = (bus.in_bits == '0) ? CW'(DATA_WIDTH) : bus.in_bits;
        shiftAmt = CW'(DATA_WIDTH) - nBits;
        if (LSB_FIRST != 0) begin
            loadWord = bus.in_data;
            shift_d  = shift_q >> 1;
            firstBit = loadWord[0];
            nextBit  = shift_d[0];
        end else begin
            loadWord = bus.in_data << shiftAmt;
            shift_d  = shift_q << 1;
            firstBit = loadWord[DATA_WIDTH-1];
            nextBit  = shift_d[DATA_WIDTH-1];
        end
    end

    assign fire   = outValid_q && bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready     = !rst && ((state_q == IDLE) || (fire && outLastBit_q));
    assign bus.out_valid    = outValid_q;
    assign bus.out_data     = outData_q;
    assign bus.out_parity   = outParity_q;
    assign bus.out_last_bit = outLastBit_q;
    assign bus.out_last     = outLast_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            last_q       <= 1'b0;
            outValid_q   <= 1'b0;
            outData_q    <= 1'b0;
            outParity_q  <= 1'b0;
            outLastBit_q <= 1'b0;
            outLast_q    <= 1'b0;
        end else if (accept) begin
            state_q      <= DATA;
            shift_q      <= loadWord;
            cnt_q        <= nBits;
            acc_q        <= 1'b0;
            last_q       <= bus.in_last;
            outValid_q   <= 1'b1;
            outData_q    <= firstBit;
            outParity_q  <= 1'b0;
            outLastBit_q <= (nBits == CW'(1)) && !PAR_ON;
            outLast_q    <= (nBits == CW'(1)) && !PAR_ON && bus.in_last;
        end else if (fire) begin
            case (state_q)
                DATA: begin
                    acc_q <= acc_q ^ outData_q;
                    if (cnt_q == CW'(1)) begin
                        if (PAR_ON) begin
                            state_q      <= PARITY;
                            outData_q    <= acc_q ^ outData_q ^ ODD_BIT;
                            outParity_q  <= 1'b1;
                            outLastBit_q <= 1'b1;
                            outLast_q    <= last_q;
                        end else begin
                            state_q      <= IDLE;
                            outValid_q   <= 1'b0;
                            outData_q    <= 1'b0;
                            outLastBit_q <= 1'b0;
                            outLast_q    <= 1'b0;
                        end
                    end else begin
                        shift_q      <= shift_d;
                        cnt_q        <= cnt_q - CW'(1);
                        outData_q    <= nextBit;
                        outLastBit_q <= (cnt_q == CW'(2)) && !PAR_ON;
                        outLast_q    <= (cnt_q == CW'(2)) && !PAR_ON && last_q;
                    end
                end
                PARITY: begin
                    state_q      <= IDLE;
                    outValid_q   <= 1'b0;
                    outData_q    <= 1'b0;
                    outParity_q  <= 1'b0;
                    outLastBit_q <= 1'b0;
                    outLast_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/param_serialiser.md
Name: param_serialiser

Overview:
Generalised successor to the ISO14443-3A byte serialiser. Converts a stream of parallel words into a bit stream for the Tx encoder. Word width and bit order are configurable. An optional per-word parity bit is inserted. Partial words are supported at any position in a frame. Sits between the frame/CRC generator and the bit encoder, with ready/valid handshakes on both sides and zero-bubble back-to-back operation.

Parameters:
DATA_WIDTH, 8, width of input word; must be >= 2.
LSB_FIRST, 1, 1: bit 0 transmitted first; 0: bit in_bits-1 transmitted first.
PARITY_EN, 1, 1: append one parity bit after each word's data bits.
PARITY_ODD, 1, 1: odd parity (ISO14443A), so data ones + parity bit is odd; 0: even parity.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  word available.
in_ready  out  1  serialiser can accept a word this cycle.
in_data  in  DATA_WIDTH  word; only bits [in_bits-1:0] are meaningful.
in_bits  in  CW=$clog2(DATA_WIDTH+1)  number of valid bits; 0 is treated as DATA_WIDTH.
in_last  in  1  word is the last word of the frame.
out_valid  out  1  out_data holds a bit.
out_ready  in  1  sink consumes the bit this cycle.
out_data  out  1  serial bit.
out_parity  out  1  current bit is a parity bit.
out_last_bit  out  1  current bit is the final bit of the word (parity bit if PARITY_EN, else last data bit).
out_last  out  1  out_last_bit of the word flagged in_last.

Behaviour:
- Reset (async assert, sync deassert handled externally): all outputs 0; state IDLE; shift register, bit counter, parity accumulator and last flag cleared. in_ready is 0 during reset and 1 in the first cycle after reset.
- States:
  - IDLE: no word loaded.
  - DATA: emitting data bits.
  - PARITY: emitting parity bit (only entered when PARITY_EN=1).
- Input handshake:
  - A word is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last_bit), i.e. combinational pass-through on the final bit.
  - in_data, in_bits and in_last are captured on acceptance.
  - An accepted word moves to DATA.
- Latency: word accepted on edge N gives its first bit on out_valid/out_data in cycle N+1. No idle cycle between words when in_valid is held.
- Output handshake:
  - A bit advances only when out_valid && out_ready.
  - While out_ready=0, all out_* signals hold stable.
  - out_valid is 1 in DATA and PARITY, 0 in IDLE.
- DATA:
  - A bit counter counts n=in_bits (or DATA_WIDTH) bits.
  - With LSB_FIRST, emit bits 0..n-1; otherwise emit n-1..0.
  - A parity accumulator XORs each emitted data bit.
  - On the transfer of the last data bit: go to PARITY if PARITY_EN; otherwise go to IDLE, or reload DATA if a word is accepted the same cycle.
- PARITY:
  - out_data = acc ^ PARITY_ODD; out_parity=1; out_last_bit=1.
  - On transfer: go to IDLE, or to DATA if a new word is accepted simultaneously.
- out_last = out_last_bit && captured in_last. in_last does not affect timing; it is only flagged through.
- Partial words are legal at any position. Parity covers only the valid bits. A 1-bit word with PARITY_EN=0 produces a single bit with out_last_bit=1.
- in_bits > DATA_WIDTH is illegal; covered by an assertion in the bench, RTL behaviour undefined.
- Reset mid-word discards the word and parity immediately; no partial bits are emitted after release.
- in_valid while in_ready=0 is ignored; the source holds the word.
- Counter widths are CW bits. No wrap: the counter reloads on each accept.

Test Plan:
- Defaults; send 0xA5, in_bits=8, in_last=1; out_ready=1 → bits 1,0,1,0,0,1,0,1, then parity 1 (4 ones, odd). out_last_bit and out_last on the 9th bit only; out_parity on the 9th bit only; first bit one cycle after accept.
- Defaults; partial word in_data=0x05, in_bits=3 → bits 1,0,1, parity 1. Then 0xFF, in_bits=0 (8) → 8 ones, parity 1. Exactly 13 contiguous valid cycles.
- Back-to-back: 10 random words with in_valid held and out_ready=1 → out_valid never drops for 90 cycles; in_ready pulses only on each parity bit.
- Backpressure: out_ready randomly 30% low on 1000 random frames of 1-80 bits (same as previous bench, now with parity) → bit stream and flags match the model; outputs stable while stalled.
- LSB_FIRST=0, PARITY_EN=0, DATA_WIDTH=16: 0x8001 → bits 1, fourteen 0s, 1; out_last_bit on the 16th bit; out_parity never set.
- Reset asserted on the 4th bit of a word → outputs 0 immediately. After release, in_ready=1 and a new word 0x3C emits 0,0,1,1,1,1,0,0 with parity 1, with no residue from the aborted word.
